// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD adder.
//   state_t      : controller states (IDLE, RUN, DONE)
//   bcd_digit_t  : one packed BCD digit
//   BCD_MAX      : largest legal BCD digit value
//   BCD_ADJ      : decimal correction added when a digit sum exceeds BCD_MAX
//   digit_invalid: flags a 4-bit value that is not a legal BCD digit
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_ADJ = 4'd6;

  function automatic logic digit_invalid(input bcd_digit_t d);
    return (d > BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder slice, purely combinational.
// Ports:
//   a, b : input digits (any 4-bit value is accepted, invalid ones included)
//   cin  : carry in
//   s    : corrected BCD sum digit
//   cout : decimal carry out
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  output bcd_digit_t s,
  output logic       cout
);

  logic [4:0] total_s;

  // Binary digit sum followed by decimal correction when it passes nine.
  always_comb begin
    total_s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (total_s > {1'b0, BCD_MAX}) begin
      // Only the low nibble survives, so (t + 6)[3:0] == t[3:0] + 6 mod 16.
      s    = total_s[3:0] + BCD_ADJ;
      cout = 1'b1;
    end else begin
      s    = total_s[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder controller: adds two DIGITS-wide packed BCD operands
// through one shared bcd_digit_add slice, least-significant digit first,
// one digit per clock.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   start     : request, honoured only in IDLE or DONE
//   a, b      : packed BCD operands (latched on acceptance)
//   carry_in  : initial carry into digit 0
//   busy      : high while digits are being processed
//   done      : one-cycle result-valid pulse
//   sum       : BCD result register
//   carry_out : carry out of the most-significant digit
//   err       : set if any operand digit exceeded nine during this operation
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  carry_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  carry_out,
  output logic                  err
);

  // The digit index keeps at least one bit so the DIGITS=1 build stays legal.
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  state_t               state_r;
  state_t               state_nxt_s;
  logic [4*DIGITS-1:0]  a_r;
  logic [4*DIGITS-1:0]  b_r;
  logic [4*DIGITS-1:0]  sum_r;
  logic [IDX_W-1:0]     idx_r;
  logic                 carry_r;
  logic                 carry_out_r;
  logic                 err_r;
  logic                 busy_r;
  logic                 done_r;

  logic                 accept_s;
  logic                 last_s;
  bcd_digit_t           a_dig_s;
  bcd_digit_t           b_dig_s;
  bcd_digit_t           s_dig_s;
  logic                 cout_dig_s;

  // Select the operand digits currently being processed.
  always_comb begin
    a_dig_s = a_r[idx_r*4 +: 4];
    b_dig_s = b_r[idx_r*4 +: 4];
  end

  bcd_digit_add u_digit (
    .a    (a_dig_s),
    .b    (b_dig_s),
    .cin  (carry_r),
    .s    (s_dig_s),
    .cout (cout_dig_s)
  );

  // Next-state logic and start acceptance.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    last_s      = (idx_r == IDX_LAST);
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          state_nxt_s = RUN;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register with registered busy/done decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == RUN);
      done_r  <= (state_nxt_s == DONE);
    end
  end

  // Operand capture and per-digit accumulation of sum, carry and error.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r         <= '0;
      b_r         <= '0;
      sum_r       <= '0;
      idx_r       <= '0;
      carry_r     <= 1'b0;
      carry_out_r <= 1'b0;
      err_r       <= 1'b0;
    end else if (accept_s) begin
      a_r         <= a;
      b_r         <= b;
      sum_r       <= '0;
      idx_r       <= '0;
      carry_r     <= carry_in;
      carry_out_r <= 1'b0;
      err_r       <= 1'b0;
    end else if (state_r == RUN) begin
      // The result digit is written even when an input digit is invalid.
      sum_r[idx_r*4 +: 4] <= s_dig_s;
      carry_r             <= cout_dig_s;
      err_r               <= err_r | digit_invalid(a_dig_s) | digit_invalid(b_dig_s);
      if (last_s) begin
        carry_out_r <= cout_dig_s;
      end else begin
        idx_r <= idx_r + IDX_W'(1);
      end
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign sum       = sum_r;
  assign carry_out = carry_out_r;
  assign err       = err_r;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
module tb_bcd_serial_add_ctrl;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, cin;
  logic [15:0] a, b, sum;
  logic        busy, done, cout, err;

  logic        start1, cin1;
  logic [3:0]  a1, b1, sum1;
  logic        busy1, done1, cout1, err1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_serial_add_ctrl #(.DIGITS(D)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .carry_in(cin),
    .busy(busy), .done(done), .sum(sum), .carry_out(cout), .err(err)
  );

  bcd_serial_add_ctrl #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .carry_in(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .carry_out(cout1), .err(err1)
  );

  // Reference: decimal addition digit by digit with the stated correction rule.
  function automatic void ref_add(input logic [63:0] x, input logic [63:0] y,
                                  input logic c, input int nd,
                                  output logic [63:0] s, output logic co, output logic er);
    int xd, yd, t;
    s  = '0;
    er = 1'b0;
    co = c;
    for (int i = 0; i < nd; i++) begin
      xd = int'(x[4*i +: 4]);
      yd = int'(y[4*i +: 4]);
      if (xd > 9 || yd > 9) er = 1'b1;
      t = xd + yd + int'(co);
      if (t > 9) begin
        s[4*i +: 4] = 4'((t + 6) % 16);
        co = 1'b1;
      end else begin
        s[4*i +: 4] = 4'(t);
        co = 1'b0;
      end
    end
  endfunction

  // One DIGITS=4 operation with timing and result checks.
  task automatic run_op(input logic [15:0] xa, input logic [15:0] xb, input logic xc, input string nm);
    logic [63:0] es;
    logic eco, eer;
    ref_add({48'h0, xa}, {48'h0, xb}, xc, D, es, eco, eer);
    @(negedge clk);
    start = 1'b1; a = xa; b = xb; cin = xc;
    @(negedge clk);
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    for (int k = 1; k <= D; k++) begin
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL %s_run k=%0d got busy=%b done=%b want busy=1 done=0", nm, k, busy, done);
      end
      @(negedge clk);
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_done got busy=%b done=%b want busy=0 done=1", nm, busy, done);
    end
    total++;
    if (sum !== es[15:0] || cout !== eco || err !== eer) begin
      bad++;
      $display("FAIL %s_result got sum=%h co=%b err=%b want sum=%h co=%b err=%b",
               nm, sum, cout, err, es[15:0], eco, eer);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, sum, cout, err} !== 20'h0) begin
      bad++;
      $display("FAIL reset4 got busy=%b done=%b sum=%h co=%b err=%b want all 0", busy, done, sum, cout, err);
    end
    total++;
    if ({busy1, done1, sum1, cout1, err1} !== 8'h0) begin
      bad++;
      $display("FAIL reset1 got busy=%b done=%b sum=%h co=%b err=%b want all 0", busy1, done1, sum1, cout1, err1);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    run_op(16'h1234, 16'h5678, 1'b0, "add1234");
    total++;
    if (sum !== 16'h6912 || cout !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL const_6912 got sum=%h co=%b err=%b want 6912 0 0", sum, cout, err);
    end
    run_op(16'h9999, 16'h0001, 1'b0, "add9999");
    total++;
    if (sum !== 16'h0000 || cout !== 1'b1) begin
      bad++;
      $display("FAIL const_overflow got sum=%h co=%b want 0000 1", sum, cout);
    end
    run_op(16'h0000, 16'h0000, 1'b1, "cin_only");
    total++;
    if (sum !== 16'h0001 || cout !== 1'b0) begin
      bad++;
      $display("FAIL const_cin got sum=%h co=%b want 0001 0", sum, cout);
    end
  endtask

  task automatic test_err();
    run_op(16'h00A5, 16'h0001, 1'b0, "bad_digit");
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL err_set got err=%b want 1", err);
    end
    run_op(16'h0005, 16'h0004, 1'b0, "err_clear");
    total++;
    if (sum !== 16'h0009 || err !== 1'b0) begin
      bad++;
      $display("FAIL err_clear_const got sum=%h err=%b want 0009 0", sum, err);
    end
  endtask

  // start held high throughout: ignored in RUN, accepted again from DONE.
  task automatic test_back_to_back();
    logic [63:0] es1, es2;
    logic co1, co2, er1, er2;
    ref_add(64'h2468, 64'h1357, 1'b1, D, es1, co1, er1);
    ref_add(64'h8080, 64'h3939, 1'b0, D, es2, co2, er2);
    @(negedge clk);
    start = 1'b1; a = 16'h2468; b = 16'h1357; cin = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= D; k++) begin
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL b2b_run1 k=%0d got busy=%b done=%b want 1 0", k, busy, done);
      end
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      @(negedge clk);
    end
    total++;
    if (done !== 1'b1 || sum !== es1[15:0] || cout !== co1) begin
      bad++;
      $display("FAIL b2b_first got done=%b sum=%h co=%b want 1 %h %b", done, sum, cout, es1[15:0], co1);
    end
    a = 16'h8080; b = 16'h3939; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= D; k++) begin
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL b2b_run2 k=%0d got busy=%b done=%b want 1 0", k, busy, done);
      end
      @(negedge clk);
    end
    total++;
    if (done !== 1'b1 || sum !== es2[15:0] || cout !== co2) begin
      bad++;
      $display("FAIL b2b_second got done=%b sum=%h co=%b want 1 %h %b", done, sum, cout, es2[15:0], co2);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    start = 1'b1; a = 16'h7777; b = 16'h8888; cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({busy, done, sum, cout, err} !== 20'h0) begin
      bad++;
      $display("FAIL mid_reset got busy=%b done=%b sum=%h co=%b err=%b want all 0", busy, done, sum, cout, err);
    end
    repeat (D + 1) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_idle got busy=%b done=%b want 0 0", busy, done);
    end
    run_op(16'h0045, 16'h0055, 1'b0, "after_reset");
    total++;
    if (sum !== 16'h0100) begin
      bad++;
      $display("FAIL const_0100 got sum=%h want 0100", sum);
    end
  endtask

  task automatic test_random();
    logic [15:0] ra, rb;
    for (int n = 0; n < 12; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      // Mostly legal BCD operands, occasionally raw 16-bit patterns.
      if ($urandom_range(3, 0) != 0) begin
        for (int i = 0; i < D; i++) begin
          ra[4*i +: 4] = 4'($urandom_range(9, 0));
          rb[4*i +: 4] = 4'($urandom_range(9, 0));
        end
      end
      run_op(ra, rb, 1'($urandom), "random");
    end
  endtask

  task automatic run_op1(input logic [3:0] xa, input logic [3:0] xb, input logic xc,
                         input logic [3:0] xs, input logic xco, input string nm);
    @(negedge clk);
    start1 = 1'b1; a1 = xa; b1 = xb; cin1 = xc;
    @(negedge clk);
    start1 = 1'b0; a1 = 4'($urandom); b1 = 4'($urandom);
    total++;
    if (busy1 !== 1'b1 || done1 !== 1'b0) begin
      bad++;
      $display("FAIL %s_run got busy=%b done=%b want 1 0", nm, busy1, done1);
    end
    @(negedge clk);
    total++;
    if (done1 !== 1'b1 || busy1 !== 1'b0 || sum1 !== xs || cout1 !== xco || err1 !== 1'b0) begin
      bad++;
      $display("FAIL %s_done got done=%b busy=%b sum=%h co=%b err=%b want 1 0 %h %b 0",
               nm, done1, busy1, sum1, cout1, err1, xs, xco);
    end
  endtask

  task automatic test_digits1();
    run_op1(4'h6, 4'h9, 1'b0, 4'h5, 1'b1, "d1_6p9");
    run_op1(4'h3, 4'h3, 1'b1, 4'h7, 1'b0, "d1_3p3c");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_err();
    test_back_to_back();
    test_mid_reset();
    test_random();
    test_digits1();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
